// File: rtl/keystream_xor_serializer_pkg.sv
// Shared cipher package: A5/1 stage constants, keystream length default,
// serializer state encoding and the nibble-to-ASCII helper.
package keystream_xor_serializer_pkg;

   // A5/1 LFSR lengths and clocking-bit positions of the keystream generator stage
   localparam int unsigned A5_R1_LEN = 19;
   localparam int unsigned A5_R2_LEN = 22;
   localparam int unsigned A5_R3_LEN = 23;
   localparam int unsigned A5_R1_CLK = 8;
   localparam int unsigned A5_R2_CLK = 10;
   localparam int unsigned A5_R3_CLK = 10;

   // Keystream / message length in bits (must be a multiple of 4)
   localparam int unsigned KS_BITS_DEFAULT = 128;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_XOR     = 3'd2,
      ST_EMIT    = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   // Upper-case hex digit for a nibble: '0'-'9' then 'A'-'F'
   function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
      logic [7:0] ch;
      if (nib < 4'd10) ch = 8'h30 + {4'h0, nib};
      else             ch = 8'h37 + {4'h0, nib};
      return ch;
   endfunction

endpackage

// File: rtl/keystream_xor_serializer_if.sv
// Bus between the keystream/message source plus LCD consumer and the serializer.
// Handshake: a character transfers on a rising clk edge where out_valid and
// out_ready are both high; while out_valid is high and out_ready is low the
// character (out_nibble/out_ascii) is held stable, and out_valid never drops
// without a transfer except on start or clrn.
interface keystream_xor_serializer_if
   import keystream_xor_serializer_pkg::*;
#(
   parameter int unsigned KS_BITS = KS_BITS_DEFAULT
);
   logic               start;
   logic               ks_valid;
   logic               ks_bit;
   logic [KS_BITS-1:0] data_in;
   logic               out_ready;
   logic               out_valid;
   logic [3:0]         out_nibble;
   logic [7:0]         out_ascii;
   logic               busy;
   logic               done;
   logic [7:0]         bit_count;
   state_t             state;      // FSM state, exported for observation

   modport master (
      output start, ks_valid, ks_bit, data_in, out_ready,
      input  out_valid, out_nibble, out_ascii, busy, done, bit_count, state
   );

   modport slave (
      input  start, ks_valid, ks_bit, data_in, out_ready,
      output out_valid, out_nibble, out_ascii, busy, done, bit_count, state
   );
endinterface

// File: rtl/keystream_xor_serializer_hex_to_ascii_char.sv
// Pure combinational nibble to ASCII hex character converter.
module hex_to_ascii_char
   import keystream_xor_serializer_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [7:0] ascii_o
);

   // Conversion depends on the nibble only
   always_comb begin
      ascii_o = nibble_to_ascii(nibble_i);
   end

endmodule

// File: rtl/keystream_xor_serializer.sv
// Collects KS_BITS keystream bits MSB-first, XORs them with a stored message
// and streams the result out one hex character at a time, most significant
// nibble first, under a valid/ready handshake.
module keystream_xor_serializer
   import keystream_xor_serializer_pkg::*;
#(
   parameter int unsigned KS_BITS = KS_BITS_DEFAULT
)(
   input  logic                       clk,
   input  logic                       clrn,
   keystream_xor_serializer_if.slave  bus
);

   localparam int unsigned NIBBLES = KS_BITS / 4;
   localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [7:0]       BIT_LAST = 8'(KS_BITS - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

   state_t             state_q;
   logic [KS_BITS-1:0] sr_q;
   logic [KS_BITS-1:0] result_q;
   logic [7:0]         bit_count_q;
   logic [IDX_W-1:0]   idx_q;
   logic [3:0]         nibble_sel;

   // Control FSM and datapath registers; start overrides every other event
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q     <= ST_IDLE;
         sr_q        <= '0;
         result_q    <= '0;
         bit_count_q <= '0;
         idx_q       <= '0;
      end else if (bus.start) begin
         // a keystream bit arriving with start is dropped on purpose
         state_q     <= ST_COLLECT;
         sr_q        <= '0;
         result_q    <= '0;
         bit_count_q <= '0;
         idx_q       <= '0;
      end else begin
         case (state_q)
            ST_COLLECT: begin
               if (bus.ks_valid) begin
                  sr_q        <= {sr_q[KS_BITS-2:0], bus.ks_bit};
                  bit_count_q <= bit_count_q + 8'd1;
                  if (bit_count_q == BIT_LAST) state_q <= ST_XOR;
               end
            end
            ST_XOR: begin
               result_q <= sr_q ^ bus.data_in;
               idx_q    <= '0;
               state_q  <= ST_EMIT;
            end
            ST_EMIT: begin
               if (bus.out_ready) begin
                  if (idx_q == IDX_LAST) state_q <= ST_DONE;
                  else                   idx_q   <= idx_q + 1'b1;
               end
            end
            default: begin
               // IDLE and DONE wait for start; stray ks_valid is ignored
               state_q <= state_q;
            end
         endcase
      end
   end

   // Select the current nibble, most significant first; zero outside EMIT
   always_comb begin
      nibble_sel = 4'h0;
      if (state_q == ST_EMIT) begin
         for (int i = 0; i < int'(NIBBLES); i++) begin
            if (idx_q == IDX_W'(i)) nibble_sel = result_q[KS_BITS-1-4*i -: 4];
         end
      end
   end

   hex_to_ascii_char u_hex_to_ascii_char (
      .nibble_i (nibble_sel),
      .ascii_o  (bus.out_ascii)
   );

   assign bus.out_nibble = nibble_sel;
   assign bus.out_valid  = (state_q == ST_EMIT);
   assign bus.busy       = (state_q == ST_COLLECT) || (state_q == ST_XOR) ||
                           (state_q == ST_EMIT);
   assign bus.done       = (state_q == ST_DONE);
   assign bus.bit_count  = bit_count_q;
   assign bus.state      = state_q;

endmodule

// File: tb/tb_keystream_xor_serializer.sv
// Scoreboard bench for keystream_xor_serializer with KS_BITS = 128.
module tb_keystream_xor_serializer;
   import keystream_xor_serializer_pkg::*;

   localparam int KB = 128;

   logic clk;
   logic clrn;
   int   n_checks;
   int   n_fail;
   int   xfer_cnt;
   logic [3:0] exp_q[$];

   keystream_xor_serializer_if #(.KS_BITS(KB)) ifc ();

   keystream_xor_serializer #(.KS_BITS(KB)) dut (
      .clk  (clk),
      .clrn (clrn),
      .bus  (ifc.slave)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired checks=%0d", n_checks);
      $fatal(1, "bench timeout");
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] ascii_of(input logic [3:0] n);
      string s;
      s = "0123456789ABCDEF";
      return s[n];
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // scoreboard: pop one expected nibble per observed transfer
   always @(negedge clk) begin
      logic [3:0] e;
      if (clrn && ifc.out_valid && ifc.out_ready) begin
         if (exp_q.size() == 0) begin
            check("sb_underflow", 128'(exp_q.size()), 128'd1);
         end else begin
            e = exp_q.pop_front();
            check("nibble", ifc.out_nibble, e);
            check("ascii", ifc.out_ascii, ascii_of(e));
         end
         xfer_cnt++;
      end
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      ifc.start = 1'b1;
      step();
      ifc.start = 1'b0;
   endtask

   task automatic push_expected(input logic [127:0] ks, input logic [127:0] data);
      logic [127:0] r;
      r = ks ^ data;
      for (int i = 0; i < KB / 4; i++) exp_q.push_back(r[127-4*i -: 4]);
   endtask

   task automatic send_bits(input logic [127:0] ks, input bit gap, output int cycles);
      cycles = 0;
      for (int i = 0; i < KB; i++) begin
         if (gap && i > 0) begin
            ifc.ks_valid = 1'b0;
            step();
            cycles++;
         end
         ifc.ks_valid = 1'b1;
         ifc.ks_bit   = ks[127-i];
         step();
         cycles++;
      end
      ifc.ks_valid = 1'b0;
      ifc.ks_bit   = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (ifc.done) break;
         step();
      end
      check("wait_done", ifc.done, 1'b1);
   endtask

   task automatic wait_xfers(input int n, input string tag);
      for (int i = 0; i < 200; i++) begin
         if (xfer_cnt == n) break;
         step();
      end
      check(tag, 128'(xfer_cnt), 128'(n));
   endtask

   initial begin
      logic [127:0] ks;
      logic [127:0] d;
      int cyc;
      n_checks = 0;
      n_fail   = 0;
      xfer_cnt = 0;
      clrn = 1'b0;
      ifc.start = 1'b0;
      ifc.ks_valid = 1'b0;
      ifc.ks_bit = 1'b0;
      ifc.data_in = '0;
      ifc.out_ready = 1'b1;

      // reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_state", ifc.state, ST_IDLE);
      check("rst_valid", ifc.out_valid, 1'b0);
      check("rst_busy", ifc.busy, 1'b0);
      check("rst_done", ifc.done, 1'b0);
      check("rst_nibble", ifc.out_nibble, 4'h0);
      check("rst_ascii", ifc.out_ascii, 8'h30);
      check("rst_bitcnt", ifc.bit_count, 8'd0);
      clrn = 1'b1;
      step();

      // all-zero keystream, counting message, ready always high
      d = 128'h0123456789ABCDEFFEDCBA9876543210;
      ifc.data_in = d;
      xfer_cnt = 0;
      pulse_start();
      check("t1_collect", ifc.state, ST_COLLECT);
      check("t1_busy", ifc.busy, 1'b1);
      push_expected('0, d);
      send_bits('0, 1'b0, cyc);
      check("t1_xor_state", ifc.state, ST_XOR);
      check("t1_lat_valid0", ifc.out_valid, 1'b0);
      check("t1_bitcnt", ifc.bit_count, 8'd128);
      step();
      check("t1_lat_valid1", ifc.out_valid, 1'b1);
      check("t1_first_nib", ifc.out_nibble, 4'h0);
      repeat (32) step();
      check("t1_done_32", ifc.done, 1'b1);
      check("t1_valid_off", ifc.out_valid, 1'b0);
      check("t1_busy_off", ifc.busy, 1'b0);
      check("t1_xfers", 128'(xfer_cnt), 128'd32);
      check("t1_sb_empty", 128'(exp_q.size()), 128'd0);

      // alternating keystream on every other cycle, zero message
      ks = {64{2'b10}};
      ifc.data_in = '0;
      xfer_cnt = 0;
      pulse_start();
      check("t2_bitcnt0", ifc.bit_count, 8'd0);
      push_expected(ks, '0);
      send_bits(ks, 1'b1, cyc);
      check("t2_cycles", 128'(cyc), 128'd255);
      check("t2_bitcnt", ifc.bit_count, 8'd128);
      wait_done(100);
      check("t2_xfers", 128'(xfer_cnt), 128'd32);
      check("t2_sb_empty", 128'(exp_q.size()), 128'd0);

      // backpressure for 5 cycles with nibble 3 on the bus
      ks = rand128();
      d  = rand128();
      ifc.data_in = d;
      xfer_cnt = 0;
      pulse_start();
      push_expected(ks, d);
      send_bits(ks, 1'b0, cyc);
      wait_xfers(3, "t3_reach_idx3");
      ifc.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("t3_bp_valid", ifc.out_valid, 1'b1);
         check("t3_bp_nibble", ifc.out_nibble, exp_q[0]);
         check("t3_bp_ascii", ifc.out_ascii, ascii_of(exp_q[0]));
      end
      check("t3_bp_xfers", 128'(xfer_cnt), 128'd3);
      ifc.out_ready = 1'b1;
      wait_done(100);
      check("t3_xfers", 128'(xfer_cnt), 128'd32);
      check("t3_sb_empty", 128'(exp_q.size()), 128'd0);

      // restart during EMIT at nibble 10
      ks = rand128();
      d  = rand128();
      ifc.data_in = d;
      xfer_cnt = 0;
      pulse_start();
      push_expected(ks, d);
      send_bits(ks, 1'b0, cyc);
      wait_xfers(10, "t4_reach_idx10");
      ifc.out_ready = 1'b0;
      pulse_start();
      check("t4_valid0", ifc.out_valid, 1'b0);
      check("t4_state", ifc.state, ST_COLLECT);
      check("t4_bitcnt", ifc.bit_count, 8'd0);
      exp_q.delete();
      xfer_cnt = 0;
      ks = rand128();
      d  = rand128();
      ifc.data_in = d;
      ifc.out_ready = 1'b1;
      push_expected(ks, d);
      send_bits(ks, 1'b0, cyc);
      wait_done(100);
      check("t4_xfers", 128'(xfer_cnt), 128'd32);
      check("t4_sb_empty", 128'(exp_q.size()), 128'd0);

      // asynchronous clear after 60 bits
      pulse_start();
      for (int i = 0; i < 60; i++) begin
         ifc.ks_valid = 1'b1;
         ifc.ks_bit   = 1'($urandom_range(0, 1));
         step();
      end
      ifc.ks_valid = 1'b0;
      check("t5_bitcnt60", ifc.bit_count, 8'd60);
      #2;
      clrn = 1'b0;
      #1;
      check("t5_state", ifc.state, ST_IDLE);
      check("t5_bitcnt", ifc.bit_count, 8'd0);
      check("t5_busy", ifc.busy, 1'b0);
      check("t5_valid", ifc.out_valid, 1'b0);
      check("t5_done", ifc.done, 1'b0);
      check("t5_ascii", ifc.out_ascii, 8'h30);
      step();
      clrn = 1'b1;
      xfer_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         ifc.ks_valid = 1'b1;
         ifc.ks_bit   = 1'($urandom_range(0, 1));
         step();
      end
      ifc.ks_valid = 1'b0;
      check("t5_idle_after", ifc.state, ST_IDLE);
      check("t5_bitcnt_after", ifc.bit_count, 8'd0);
      check("t5_no_xfer", 128'(xfer_cnt), 128'd0);

      // start together with ks_valid, then 129 pulses
      ks = rand128();
      d  = rand128();
      ifc.data_in = d;
      xfer_cnt = 0;
      ifc.start = 1'b1;
      ifc.ks_valid = 1'b1;
      ifc.ks_bit = 1'b1;
      step();
      ifc.start = 1'b0;
      ifc.ks_valid = 1'b0;
      check("t6_bitcnt0", ifc.bit_count, 8'd0);
      check("t6_state", ifc.state, ST_COLLECT);
      push_expected(ks, d);
      send_bits(ks, 1'b0, cyc);
      ifc.ks_valid = 1'b1;
      ifc.ks_bit = ~ks[0];
      step();
      ifc.ks_valid = 1'b0;
      check("t6_bitcnt_sat", ifc.bit_count, 8'd128);
      check("t6_emit", ifc.state, ST_EMIT);
      wait_done(100);
      check("t6_xfers", 128'(xfer_cnt), 128'd32);
      check("t6_sb_empty", 128'(exp_q.size()), 128'd0);

      // final report
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
